ps2_host_transmitter: RTL

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the shared PS2_CLK/PS2_DAT open-drain lines. It sits beside the keyboard receive driver on the same pins. While `busy` is high, the receive path must ignore line activity. The block runs the full host request sequence: inhibit, request-to-send, device-clocked bit shifting, acknowledge check and timeouts.

---
 rtl/ps2_host_transmitter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard
// over the shared open-drain PS2_CLK/PS2_DAT lines. It runs the full host
// request sequence: inhibit, request-to-send, device-clocked shifting,
// acknowledge check and timeouts. The receive path must ignore line
// activity while busy is high.
//
// Ports:
//   CLOCK_50  in     50 MHz system clock
//   reset     in     asynchronous active-low reset
//   send      in     single-cycle request, sampled only when idle
//   cmd_byte  in     byte to transmit, latched on an accepted send
//   PS2_CLK   inout  open-drain clock: driven 0 or released, never driven 1
//   PS2_DAT   inout  open-drain data: driven 0 or released, never driven 1
//   busy      out    high from the accepted send until back in idle
//   done      out    one-cycle pulse on acknowledged completion
//   error     out    one-cycle pulse on timeout or missing ack
module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned REQ_CYCLES     = 100,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] cmd_byte,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_CLK  = 3'd3;
  localparam logic [2:0] S_SHIFT     = 3'd4;
  localparam logic [2:0] S_ACK       = 3'd5;
  localparam logic [2:0] S_WAIT_IDLE = 3'd6;

  localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] REQ_LAST     = 20'(REQ_CYCLES - 1);
  localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] XFER_LAST    = 20'(XFER_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  frame_q, frame_d;
  logic        clk_low_q, clk_low_d;
  logic        dat_low_q, dat_low_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        clk_s1_q, clk_s2_q, clk_prev_q;
  logic        dat_s1_q, dat_s2_q;
  logic        fe;
  logic        fail;

  // Line drivers come straight from reset-cleared flops, so an asserted
  // reset releases both lines without waiting for a clock edge.
  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

  assign fe    = clk_prev_q & ~clk_s2_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

  // The failure state is folded into the transition itself: the cycle that
  // detects a timeout or missing ack releases the lines, pulses error and
  // returns to idle, so error and the busy drop land on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    clk_low_d = clk_low_q;
    dat_low_d = dat_low_q;
    done_d    = 1'b0;
    fail      = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        if (send) begin
          frame_d   = {1'b1, ~(^cmd_byte), cmd_byte};
          state_d   = S_INHIBIT;
          cnt_d     = '0;
          idx_d     = '0;
          clk_low_d = 1'b1;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          dat_low_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_REQ: begin
        if (cnt_q == REQ_LAST) begin
          state_d   = S_WAIT_CLK;
          cnt_d     = '0;
          clk_low_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_WAIT_CLK: begin
        // Timeout wins over a falling edge seen in the same cycle.
        if (cnt_q == START_LAST) begin
          fail = 1'b1;
        end else if (fe) begin
          state_d   = S_SHIFT;
          cnt_d     = '0;
          idx_d     = 4'd1;
          dat_low_d = ~frame_q[0];
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == XFER_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
          if (fe) begin
            dat_low_d = ~frame_q[idx_q];
            idx_d     = idx_q + 4'd1;
            if (idx_q == 4'd9) state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (cnt_q == XFER_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
          if (fe) begin
            if (!dat_s2_q) state_d = S_WAIT_IDLE;
            else           fail    = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (cnt_q == XFER_LAST) begin
          fail = 1'b1;
        end else if (clk_s2_q && dat_s2_q) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          clk_low_d = 1'b0;
          dat_low_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
      end
    endcase

    if (fail) begin
      state_d   = S_IDLE;
      clk_low_d = 1'b0;
      dat_low_d = 1'b0;
    end
    error_d = fail;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      clk_low_q  <= 1'b0;
      dat_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      clk_low_q  <= clk_low_d;
      dat_low_q  <= dat_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_s1_q   <= PS2_CLK;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= PS2_DAT;
      dat_s2_q   <= dat_s1_q;
    end
  end

endmodule
